// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester ports (CPU = port 0, DMA = port 1) and the
//   single-ported memory bus that mem_arbiter multiplexes between them.
//
//   slave  : arbiter view (requests and mem_rdata in; acks, grants, strobes out)
//   master : environment view (requesters + memory model), the mirror image
//
//   Requester side : reqN, wrN, addrN, wdataN  -> ackN, rdataN, grantN
//   Memory side    : readM, writeM, address, mem_wdata  <- mem_rdata
//   Status         : busy
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 req0,   req1;
  logic                 wr0,    wr1;
  logic [WORD_SIZE-1:0] addr0,  addr1;
  logic [WORD_SIZE-1:0] wdata0, wdata1;
  logic                 ack0,   ack1;
  logic [WORD_SIZE-1:0] rdata0, rdata1;
  logic                 grant0, grant1;
  logic                 readM,  writeM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, grant0, grant1,
           readM, writeM, address, mem_wdata, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, grant0, grant1,
           readM, writeM, address, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter in front of a fixed-latency memory.
//   One transaction is in flight at a time: IDLE -> ACCESS (MEM_LATENCY
//   cycles of readM/writeM) -> DONE (one-cycle ack) -> IDLE.
//
//   Parameters
//     WORD_SIZE   : address/data width
//     MEM_LATENCY : cycles each strobe is held (1..15)
//
//   Ports
//     clk     : clock, all state changes on posedge
//     reset_n : asynchronous reset, ACTIVE HIGH despite the name
//     bus     : mem_arbiter_if.slave (requesters, memory bus, busy)
// ---------------------------------------------------------------------------

// Per-port read-data holding register. Loads only on a read completion for
// its own port, so writes and the other port's traffic leave it untouched.
module mem_arbiter_port #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_cap,
  input  logic [WORD_SIZE-1:0] i_data,
  output logic [WORD_SIZE-1:0] o_rdata
);
  logic [WORD_SIZE-1:0] r_rdata;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)    r_rdata <= '0;
    else if (i_cap) r_rdata <= i_data;
  end

  assign o_rdata = r_rdata;
endmodule

module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;
  localparam int CW        = 4;   // holds MEM_LATENCY-1 for the full 1..15 range

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                              r_state;
  logic [CW-1:0]                       r_cnt;
  logic                                r_last;    // port served most recently
  logic                                r_sel;     // port owning the current access
  logic                                r_wr;
  logic [NUM_PORTS-1:0]                r_ack;
  logic [NUM_PORTS-1:0]                r_grant;
  logic                                r_readM;
  logic                                r_writeM;
  logic                                r_busy;
  logic [WORD_SIZE-1:0]                r_addr;
  logic [WORD_SIZE-1:0]                r_wdata;

  logic [NUM_PORTS-1:0]                w_req;
  logic [NUM_PORTS-1:0]                w_wr;
  logic [NUM_PORTS-1:0][WORD_SIZE-1:0] w_addr;
  logic [NUM_PORTS-1:0][WORD_SIZE-1:0] w_wdata;
  logic [NUM_PORTS-1:0][WORD_SIZE-1:0] w_rdata;
  logic [NUM_PORTS-1:0]                w_cap;
  logic                                w_win;
  logic                                w_last_cyc;

  assign w_req   = {bus.req1,   bus.req0};
  assign w_wr    = {bus.wr1,    bus.wr0};
  assign w_addr  = {bus.addr1,  bus.addr0};
  assign w_wdata = {bus.wdata1, bus.wdata0};

  // Round robin: a lone requester wins outright; on a tie the port that was
  // not served last wins. r_last resets to port 1 so port 0 takes the first tie.
  always_comb begin
    w_win = 1'b0;
    if (&w_req) w_win = ~r_last;
    else        w_win = w_req[1];
  end

  assign w_last_cyc = (r_state == S_ACCESS) && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_wr     <= 1'b0;
      r_ack    <= '0;
      r_grant  <= '0;
      r_readM  <= 1'b0;
      r_writeM <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_state  <= S_ACCESS;
            r_sel    <= w_win;
            r_wr     <= w_wr[w_win];
            r_grant  <= w_win ? 2'b10 : 2'b01;
            r_readM  <= ~w_wr[w_win];
            r_writeM <=  w_wr[w_win];
            r_addr   <= w_addr[w_win];
            r_wdata  <= w_wdata[w_win];
            r_cnt    <= CW'(MEM_LATENCY - 1);
            r_busy   <= 1'b1;
          end
        end
        S_ACCESS: begin
          // Requests are ignored here: the latched transaction always runs out.
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_readM  <= 1'b0;
            r_writeM <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack    <= r_sel ? 2'b10 : 2'b01;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ack   <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_sel;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data is sampled on the edge that closes the last strobe cycle.
  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      assign w_cap[p] = w_last_cyc && !r_wr && (r_sel == 1'(p));

      mem_arbiter_port #(.WORD_SIZE(WORD_SIZE)) u_port (
        .clk     (clk),
        .reset_n (reset_n),
        .i_cap   (w_cap[p]),
        .i_data  (bus.mem_rdata),
        .o_rdata (w_rdata[p])
      );
    end
  endgenerate

  assign bus.ack0      = r_ack[0];
  assign bus.ack1      = r_ack[1];
  assign bus.grant0    = r_grant[0];
  assign bus.grant1    = r_grant[1];
  assign bus.rdata0    = w_rdata[0];
  assign bus.rdata1    = w_rdata[1];
  assign bus.readM     = r_readM;
  assign bus.writeM    = r_writeM;
  assign bus.address   = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int W  = 16;
  localparam int LA = 2;
  localparam int LB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_SIZE(W)) ifa ();
  mem_arbiter_if #(.WORD_SIZE(W)) ifb ();

  mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LA)) dut_a (.clk(clk), .reset_n(rst), .bus(ifa.slave));
  mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(LB)) dut_b (.clk(clk), .reset_n(rst), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        port;
    bit        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrd;
    logic [15:0] erd0;
    logic [15:0] erd1;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {readM, writeM, grant1, grant0, ack1, ack0, busy}
  function automatic logic [6:0] ctl_a();
    return {ifa.readM, ifa.writeM, ifa.grant1, ifa.grant0, ifa.ack1, ifa.ack0, ifa.busy};
  endfunction
  function automatic logic [6:0] ctl_b();
    return {ifb.readM, ifb.writeM, ifb.grant1, ifb.grant0, ifb.ack1, ifb.ack0, ifb.busy};
  endfunction

  task automatic init_inputs();
    ifa.req0 = 0; ifa.req1 = 0; ifa.wr0 = 0; ifa.wr1 = 0;
    ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0; ifa.mem_rdata = '0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.wr0 = 0; ifb.wr1 = 0;
    ifb.addr0 = '0; ifb.addr1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0; ifb.mem_rdata = '0;
  endtask

  task automatic wait_idle_a(input string nm);
    for (int c = 0; c < 10 && ifa.busy; c++) tick();
    chk(nm, 32'(ifa.busy), 32'd0);
  endtask

  // One single-port transaction on dut_a, checked cycle by cycle.
  task automatic run_vec(input int i, input vec_t v);
    if (v.port) begin ifa.req1 = 1; ifa.wr1 = v.wr; ifa.addr1 = v.addr; ifa.wdata1 = v.wdata; end
    else        begin ifa.req0 = 1; ifa.wr0 = v.wr; ifa.addr0 = v.addr; ifa.wdata0 = v.wdata; end
    ifa.mem_rdata = v.mrd;
    for (int d = 0; d < LA; d++) begin
      tick();
      chk($sformatf("v%0d_acc%0d_ctl", i, d), 32'(ctl_a()),
          32'({!v.wr, v.wr, v.port, !v.port, 1'b0, 1'b0, 1'b1}));
      chk($sformatf("v%0d_acc%0d_bus", i, d), {ifa.address, ifa.mem_wdata}, {v.addr, v.wdata});
    end
    tick();
    chk($sformatf("v%0d_done_ctl", i), 32'(ctl_a()),
        32'({1'b0, 1'b0, v.port, !v.port, v.port, !v.port, 1'b1}));
    chk($sformatf("v%0d_done_bus", i), {ifa.address, ifa.mem_wdata}, 32'h0);
    chk($sformatf("v%0d_rdata", i), {ifa.rdata0, ifa.rdata1}, {v.erd0, v.erd1});
    if (v.port) ifa.req1 = 0; else ifa.req0 = 0;
    tick();
    chk($sformatf("v%0d_idle_ctl", i), 32'(ctl_a()), 32'h0);
  endtask

  initial begin
    tbl[0] = '{port:1'b0, wr:1'b0, addr:16'h0040, wdata:16'h0000, mrd:16'hBEEF, erd0:16'hBEEF, erd1:16'h0000};
    tbl[1] = '{port:1'b1, wr:1'b0, addr:16'h00FF, wdata:16'h0000, mrd:16'h5A5A, erd0:16'hBEEF, erd1:16'h5A5A};
    tbl[2] = '{port:1'b1, wr:1'b1, addr:16'h0010, wdata:16'h1234, mrd:16'hDEAD, erd0:16'hBEEF, erd1:16'h5A5A};
    tbl[3] = '{port:1'b0, wr:1'b1, addr:16'hFFFF, wdata:16'h0001, mrd:16'h9999, erd0:16'hBEEF, erd1:16'h5A5A};
    tbl[4] = '{port:1'b0, wr:1'b0, addr:16'h0000, wdata:16'hCAFE, mrd:16'h0000, erd0:16'h0000, erd1:16'h5A5A};
    tbl[5] = '{port:1'b1, wr:1'b0, addr:16'h8001, wdata:16'h0000, mrd:16'hFFFF, erd0:16'h0000, erd1:16'hFFFF};

    init_inputs();
    rst = 1;
    tick(); tick();
    chk("rst_ctl_a", 32'(ctl_a()), 32'h0);
    chk("rst_bus_a", {ifa.address, ifa.mem_wdata}, 32'h0);
    chk("rst_rd_a",  {ifa.rdata0, ifa.rdata1}, 32'h0);
    chk("rst_ctl_b", 32'(ctl_b()), 32'h0);
    rst = 0;
    tick();

    // --- table-driven single transactions
    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // --- both ports requesting continuously: strict alternation from reset
    begin
      int  nseen = 0;
      int  both  = 0;
      logic [3:0] order = '0;
      logic pg0 = 0, pg1 = 0;
      rst = 1; tick(); rst = 0;
      ifa.req0 = 1; ifa.req1 = 1; ifa.wr0 = 0; ifa.wr1 = 0;
      ifa.addr0 = 16'h0100; ifa.addr1 = 16'h0200;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (ifa.grant0 && ifa.grant1) both++;
        if (ifa.grant0 && !pg0) begin if (nseen < 4) order[nseen] = 1'b0; nseen++; end
        if (ifa.grant1 && !pg1) begin if (nseen < 4) order[nseen] = 1'b1; nseen++; end
        pg0 = ifa.grant0; pg1 = ifa.grant1;
      end
      chk("tie_count_ge4", 32'(nseen >= 4), 32'd1);
      chk("tie_order", 32'(order), 32'(4'b1010));
      chk("tie_both_grant", 32'(both), 32'd0);
      ifa.req0 = 0; ifa.req1 = 0;
      wait_idle_a("tie_idle");
      tick();
    end

    // --- request dropped during ACCESS still completes
    begin
      int nrd, nack;
      ifa.req0 = 1; ifa.wr0 = 0; ifa.addr0 = 16'h0ABC; ifa.mem_rdata = 16'h1111;
      tick();
      nrd = 32'(ifa.readM); nack = 32'(ifa.ack0);
      ifa.req0 = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        nrd += 32'(ifa.readM); nack += 32'(ifa.ack0);
      end
      chk("drop_readM_cycles", 32'(nrd), 32'(LA));
      chk("drop_ack_count", 32'(nack), 32'd1);
      chk("drop_rdata0", 32'(ifa.rdata0), 32'h1111);
    end

    // --- reset in the middle of a read
    begin
      ifa.req0 = 1; ifa.wr0 = 0; ifa.addr0 = 16'h0321; ifa.mem_rdata = 16'h7777;
      tick();
      chk("mid_pre_ctl", 32'(ctl_a()), 32'(7'b1001001));
      #2 rst = 1;
      #1;
      chk("mid_rst_ctl", 32'(ctl_a()), 32'h0);
      chk("mid_rst_bus", {ifa.address, ifa.mem_wdata}, 32'h0);
      chk("mid_rst_rd",  {ifa.rdata0, ifa.rdata1}, 32'h0);
      tick();
      chk("mid_rst_noack", 32'(ctl_a()), 32'h0);
      ifa.req1 = 1;
      rst = 0;
      tick();
      chk("mid_after_tie", 32'({ifa.grant1, ifa.grant0}), 32'(2'b01));
      ifa.req0 = 0; ifa.req1 = 0;
      wait_idle_a("mid_idle");
    end

    // --- MEM_LATENCY=1, port 1 reads back to back
    begin
      logic [6:0] exp;
      ifb.req1 = 1; ifb.wr1 = 0; ifb.addr1 = 16'h0055; ifb.mem_rdata = 16'hA000;
      for (int c = 0; c < 12; c++) begin
        tick();
        case (c % 3)
          0:       exp = 7'b1010001;
          1:       exp = 7'b0010101;
          default: exp = 7'b0000000;
        endcase
        chk($sformatf("l1_c%0d_ctl", c), 32'(ctl_b()), 32'(exp));
        if (c % 3 == 1) chk($sformatf("l1_c%0d_rd1", c), 32'(ifb.rdata1), 32'(16'hA000 + 16'(c - 1)));
        if (c % 3 == 0) chk($sformatf("l1_c%0d_addr", c), 32'(ifb.address), 32'h0055);
        ifb.mem_rdata = 16'(16'hA000 + 16'(c));
        if (c == 11) ifb.req1 = 0;
      end
    end

    // --- randomized traffic against a schedule-based reference model
    begin
      int   e = 0, start = -100, free_at = 0, d;
      bit   win = 0, mwr = 0, last = 1, acc, don, r0, r1;
      logic [15:0] maddr = '0, mwd = '0;
      logic [15:0] erd [2];
      init_inputs();
      rst = 1; tick(); rst = 0;
      erd[0] = '0; erd[1] = '0;
      for (int n = 0; n < 400; n++) begin
        @(posedge clk);
        r0 = ifa.req0; r1 = ifa.req1;
        if (e - start == LA && !mwr) erd[win] = ifa.mem_rdata;
        if (e >= free_at && (r0 || r1)) begin
          win     = (r0 && r1) ? !last : r1;
          last    = win;
          start   = e;
          free_at = e + LA + 2;
          mwr     = win ? ifa.wr1    : ifa.wr0;
          maddr   = win ? ifa.addr1  : ifa.addr0;
          mwd     = win ? ifa.wdata1 : ifa.wdata0;
        end
        #1;
        d   = e - start;
        acc = (d >= 0) && (d < LA);
        don = (d == LA);
        chk("rnd_ctl", 32'(ctl_a()),
            32'({acc && !mwr, acc && mwr, (acc || don) && win, (acc || don) && !win,
                 don && win, don && !win, acc || don}));
        chk("rnd_bus", {ifa.address, ifa.mem_wdata}, acc ? {maddr, mwd} : 32'h0);
        chk("rnd_rd", {ifa.rdata0, ifa.rdata1}, {erd[0], erd[1]});
        // port 0 requester
        if (don && !win) begin
          if ($urandom_range(3) != 0) ifa.req0 = 0;
          else begin ifa.wr0 = 1'($urandom); ifa.addr0 = 16'($urandom); ifa.wdata0 = 16'($urandom); end
        end else if (!ifa.req0) begin
          if ($urandom_range(2) == 0) begin
            ifa.req0 = 1; ifa.wr0 = 1'($urandom); ifa.addr0 = 16'($urandom); ifa.wdata0 = 16'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          ifa.req0 = 1'($urandom); ifa.addr0 = 16'($urandom);
        end
        // port 1 requester
        if (don && win) begin
          if ($urandom_range(3) != 0) ifa.req1 = 0;
          else begin ifa.wr1 = 1'($urandom); ifa.addr1 = 16'($urandom); ifa.wdata1 = 16'($urandom); end
        end else if (!ifa.req1) begin
          if ($urandom_range(2) == 0) begin
            ifa.req1 = 1; ifa.wr1 = 1'($urandom); ifa.addr1 = 16'($urandom); ifa.wdata1 = 16'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          ifa.req1 = 1'($urandom); ifa.addr1 = 16'($urandom);
        end
        ifa.mem_rdata = 16'($urandom);
        e++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
